spi_reg_bank: RTL and testbench

Parametrised SPI mode-0 peripheral that generalises the fixed 5x8-bit write-only enable/PWM register block into a NUM_REGS x DATA_W register bank with read-back over CIPO. Frame is {R/W, address[ADDR_W], data[DATA_W]}, MSB first. It sits between the chip pins (nCS/SCLK/COPI/CIPO) and the output-enable/PWM logic, which consume the flattened register bus and per-register write strobes.

---
 rtl/spi_reg_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_reg_bank.sv | 187 ++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_bank shared types: FSM states, R/W encoding, frame length helper.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_bits(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async input with registered
// edge detect; rise_o/fall_o are single-clk pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              lvl;

  assign lvl = sync_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank, frame {R/W, addr, data} MSB first.
// Optional SPI_REG_ERR_CNT_EN: error counter readable at NUM_REGS.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe
);

  localparam int CMD_W      = 1 + ADDR_W;
  localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
  localparam int CW         = $clog2(FRAME_BITS + 1);

  logic ncs_rise, ncs_fall;
  logic sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] copi_q;
  logic copi_s;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (nCS),
    .rise_o(ncs_rise),
    .fall_o(ncs_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (SCLK),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) copi_q <= '0;
    else        copi_q <= {copi_q[SYNC_STAGES-2:0], COPI};
  end

  assign copi_s = copi_q[SYNC_STAGES-1];

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [CMD_W-1:0]    cmd_nx;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   out_q;
  logic [DATA_W-1:0]   rd_val;
  logic                cipo_q;
  logic                oe_q;
  logic [NUM_REGS-1:0] strobe_q;
  logic [NUM_REGS-1:0] wr_hit;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                commit;

  assign cmd_nx = CMD_W'({cmd_q, copi_s});
  assign commit = ncs_rise && state_q == S_DONE &&
                  cmd_q[ADDR_W] == RW_WRITE;

`ifdef SPI_REG_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (ncs_rise) begin
      if (state_q == S_CMD || state_q == S_DATA) begin
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
      end else if (commit) begin
        if (cmd_q[ADDR_W-1:0] == ADDR_W'(NUM_REGS))
          err_q <= '0;
        else if (!(|wr_hit) && err_q != 8'hFF)
          err_q <= err_q + 8'd1;
      end
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_nx[ADDR_W-1:0] == ADDR_W'(i))
        rd_val = regs_q[i];
`ifdef SPI_REG_ERR_CNT_EN
    if (cmd_nx[ADDR_W-1:0] == ADDR_W'(NUM_REGS))
      rd_val = DATA_W'(err_q);
`endif
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_hit[i] = (cmd_q[ADDR_W-1:0] == ADDR_W'(i));
  end

  // nCS rise has priority over any SCLK edge in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      out_q    <= '0;
      cipo_q   <= 1'b0;
      oe_q     <= 1'b0;
      strobe_q <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else begin
      strobe_q <= '0;
      if (ncs_rise) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        cipo_q  <= 1'b0;
        if (commit) begin
          strobe_q <= wr_hit;
          for (int i = 0; i < NUM_REGS; i++)
            if (wr_hit[i]) regs_q[i] <= data_q;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (ncs_fall) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              cmd_q <= cmd_nx;
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == CW'(ADDR_W)) begin
                state_q <= S_DATA;
                if (cmd_nx[ADDR_W] == RW_READ) begin
                  out_q <= rd_val;
                  oe_q  <= 1'b1;
                end
              end
            end
          end
          S_DATA: begin
            if (sclk_rise) begin
              data_q <= DATA_W'({data_q, copi_s});
              cnt_q  <= cnt_q + CW'(1);
              if (cnt_q == CW'(FRAME_BITS - 1))
                state_q <= S_DONE;
            end else if (sclk_fall && oe_q) begin
              cipo_q <= out_q[DATA_W-1];
              out_q  <= out_q << 1;
            end
          end
          S_DONE: begin
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign CIPO      = cipo_q;
  assign cipo_oe   = oe_q;
  assign wr_strobe = strobe_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: default 8/7/5 instance plus a 16/4/8
// instance, scoreboard of expected register/read-back values.
module tb_spi_reg_bank;

  localparam int HALF = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic ncs0, sclk0, copi0, cipo0, oe0;
  logic ncs1, sclk1, copi1, cipo1, oe1;
  logic [39:0]  regs0;
  logic [4:0]   stb0;
  logic [127:0] regs1;
  logic [7:0]   stb1;

  always #5 clk = ~clk;

  spi_reg_bank u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .nCS      (ncs0),
    .SCLK     (sclk0),
    .COPI     (copi0),
    .CIPO     (cipo0),
    .cipo_oe  (oe0),
    .regs_flat(regs0),
    .wr_strobe(stb0)
  );

  spi_reg_bank #(
    .DATA_W  (16),
    .ADDR_W  (4),
    .NUM_REGS(8)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .nCS      (ncs1),
    .SCLK     (sclk1),
    .COPI     (copi1),
    .CIPO     (cipo1),
    .cipo_oe  (oe1),
    .regs_flat(regs1),
    .wr_strobe(stb1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int sel_cur = 0;
  int exp_q[$];
  logic [15:0] m0 [5];
  logic [15:0] m1 [8];
  int err_m [2];

  logic cipo_s, oe_s;
  logic [7:0] stb_s;
  logic [127:0] regs_s;

  always_comb begin
    if (sel_cur == 0) begin
      cipo_s = cipo0;
      oe_s   = oe0;
      stb_s  = {3'b0, stb0};
      regs_s = {88'b0, regs0};
    end else begin
      cipo_s = cipo1;
      oe_s   = oe1;
      stb_s  = stb1;
      regs_s = regs1;
    end
  end

  logic [31:0]  rd_r;
  logic         oe_cmd_r, oe_dat_r, oe_end_r, cipo_end_r;
  logic [7:0]   stb_or_r;
  int           stb_cyc_r;
  logic [127:0] regs4_r;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic n, input logic s,
                       input logic c);
    if (sel == 0) begin
      ncs0 = n; sclk0 = s; copi0 = c;
    end else begin
      ncs1 = n; sclk1 = s; copi1 = c;
    end
  endtask

  function automatic logic [127:0] exp_regs(input int sel);
    logic [127:0] r;
    r = '0;
    if (sel == 0)
      for (int i = 0; i < 5; i++) r[i*8 +: 8] = m0[i][7:0];
    else
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = m1[i];
    return r;
  endfunction

  function automatic int model_rd(input int sel, input int addr);
    int nr;
    nr = (sel != 0) ? 8 : 5;
    if (addr < nr) return (sel != 0) ? int'(m1[addr]) : int'(m0[addr]);
`ifdef SPI_REG_ERR_CNT_EN
    if (addr == nr) return err_m[sel];
`endif
    return 0;
  endfunction

  task automatic frame(input int sel, input logic rw, input int addr,
                       input int data, input int nbits);
    int aw, dw, tot;
    logic b;
    aw = (sel != 0) ? 4 : 7;
    dw = (sel != 0) ? 16 : 8;
    tot = 1 + aw + dw;
    sel_cur = sel;
    rd_r = '0; oe_cmd_r = 1'b0; oe_dat_r = 1'b1;
    stb_or_r = '0; stb_cyc_r = 0; regs4_r = '0;
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b0);
    #HALF;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0)       b = rw;
      else if (k <= aw) b = addr[aw-k];
      else if (k < tot) b = data[aw+dw-k];
      else              b = k[0];
      drive(sel, 1'b0, 1'b0, b);
      #HALF;
      if (k > aw && k < tot) begin
        rd_r = {rd_r[30:0], cipo_s};
        oe_dat_r = oe_dat_r & oe_s;
      end else if (k <= aw) begin
        oe_cmd_r = oe_cmd_r | oe_s;
      end
      drive(sel, 1'b0, 1'b1, b);
      #HALF;
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    #HALF;
    drive(sel, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (stb_s != 0) begin
        stb_or_r = stb_or_r | stb_s;
        stb_cyc_r++;
      end
      if (c == 3) regs4_r = regs_s;
    end
    oe_end_r = oe_s;
    cipo_end_r = cipo_s;
    repeat (4) @(negedge clk);
  endtask

  task automatic wr(input int sel, input int addr, input int data,
                    input int extra);
    int aw, dw, nr, e;
    logic [127:0] mask;
    aw = (sel != 0) ? 4 : 7;
    dw = (sel != 0) ? 16 : 8;
    nr = (sel != 0) ? 8 : 5;
    data = data & ((1 << dw) - 1);
    if (addr < nr) exp_q.push_back(data);
    frame(sel, 1'b1, addr, data, 1 + aw + dw + extra);
    if (addr < nr) begin
      if (sel != 0) m1[addr] = 16'(data);
      else          m0[addr] = 16'(data);
    end else if (addr == nr) begin
      err_m[sel] = 0;
    end else if (err_m[sel] < 255) begin
      err_m[sel]++;
    end
    chk("wr_strobe", stb_or_r, (addr < nr) ? 8'(1 << addr) : 8'h0);
    chk("wr_strobe_cycles", stb_cyc_r, (addr < nr) ? 1 : 0);
    chk("wr_regs_by_edge4", regs4_r, exp_regs(sel));
    if (stb_cyc_r != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      mask = (128'd1 << dw) - 128'd1;
      chk("wr_data", (regs4_r >> (addr * dw)) & mask, e);
    end
  endtask

  task automatic rd(input int sel, input int addr);
    int aw, dw, e;
    aw = (sel != 0) ? 4 : 7;
    dw = (sel != 0) ? 16 : 8;
    exp_q.push_back(model_rd(sel, addr));
    frame(sel, 1'b0, addr, 0, 1 + aw + dw);
    e = exp_q.pop_front();
    chk("rd_data", rd_r, e);
    chk("rd_oe_cmd_phase", oe_cmd_r, 1'b0);
    chk("rd_oe_data_phase", oe_dat_r, 1'b1);
    chk("rd_oe_after", oe_end_r, 1'b0);
    chk("rd_cipo_after", cipo_end_r, 1'b0);
    chk("rd_no_strobe", stb_cyc_r, 0);
    chk("rd_regs_kept", regs4_r, exp_regs(sel));
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) m0[i] = '0;
    for (int i = 0; i < 8; i++) m1[i] = '0;
    err_m[0] = 0;
    err_m[1] = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    wr(0, 2, 8'h55, 0);

    sel_cur = 0;
    @(negedge clk);
    ncs0 = 1'b0;
    #HALF;
    for (int k = 0; k < 5; k++) begin
      copi0 = 1'b1; sclk0 = 1'b1; #HALF;
      sclk0 = 1'b0; #HALF;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regs", regs0, 40'h0);
    chk("rst_oe", oe0, 1'b0);
    chk("rst_strobe", stb0, 5'h0);
    chk("rst_cipo", cipo0, 1'b0);
    ncs0 = 1'b1; copi0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) m0[i] = '0;
    err_m[0] = 0;
    repeat (4) @(negedge clk);

    wr(0, 4, 8'hA5, 0);
    rd(0, 4);

    frame(0, 1'b1, 1, 8'hFF, 12);
    err_m[0]++;
    chk("short_no_strobe", stb_cyc_r, 0);
    chk("short_regs", regs4_r, exp_regs(0));
`ifdef SPI_REG_ERR_CNT_EN
    rd(0, 5);
`endif

    wr(0, 7'h7F, 8'h3C, 0);
    rd(0, 7'h7F);

    wr(0, 0, 8'h3C, 4);
    rd(0, 0);
    rd(0, 2);

    for (int n = 0; n < 4; n++)
      wr(0, int'($urandom_range(0, 4)), int'($urandom_range(0, 255)), 0);
    for (int a = 0; a < 5; a++) rd(0, a);

    wr(1, 7, 16'hBEEF, 0);
    chk("p16_reg7_slice", regs1[127:112], 16'hBEEF);
    rd(1, 7);
    wr(1, 3, int'($urandom_range(0, 65535)), 0);
    rd(1, 3);
    rd(1, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
